// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the 4x4 keypad scanner:
//                per-scan result kinds, debounce states, matrix dimensions
//                and a row-counting helper.
//  Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    // Outcome of one complete four-column scan.
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        KEY   = 2'd1,
        MULTI = 2'd2
    } scan_result_t;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } db_state_t;

    // Number of rows pulled low (rows are active-low).
    function automatic logic [2:0] count_low_rows(input logic [NUM_ROWS-1:0] rows);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows[i]) cnt = cnt + 3'd1;
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Key output channel of the scanner. key_code/key_valid form a
//                valid/ready handshake with key_ready; key_held and overrun
//                are status flags.
//  Modports    : master - the scanner (drives code/valid/held/overrun)
//                slave  - the consumer (drives key_ready)
//  Revision    : 1.0  initial release
// ============================================================================
interface keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overrun,
        output key_ready
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_debounce
//  Description : Press/release debouncer operating on whole-scan results.
//                A press is accepted after DEBOUNCE_SCANS consecutive scans
//                reporting the same single key; a release after the same
//                number of consecutive empty scans.
//  Ports       : clk, rst (async, active-low)
//                res_strobe  - one-cycle strobe, a scan result is present
//                res, res_code - scan result kind and key code
//                press_evt   - one-cycle press event (same cycle as strobe)
//                press_code  - code accompanying press_evt
//                key_held    - debounced key-down state
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         res_strobe,
    input  scan_result_t res,
    input  logic [3:0]   res_code,
    output logic         press_evt,
    output logic [3:0]   press_code,
    output logic         key_held
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_SCANS);

    db_state_t     state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_TARGET) ? v : v + CW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RELEASED;
            cand  <= 4'd0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    // One counter serves both directions: it counts matching presses while
    // RELEASED and empty scans while PRESSED, and is cleared on each change.
    always_comb begin
        state_n   = state;
        cand_n    = cand;
        cnt_n     = cnt;
        press_evt = 1'b0;
        if (res_strobe) begin
            case (state)
                RELEASED: begin
                    if (res == KEY) begin
                        if (res_code == cand) begin
                            cnt_n = sat_inc(cnt);
                        end else begin
                            cand_n = res_code;
                            cnt_n  = CW'(1);
                        end
                    end else begin
                        cnt_n = '0;
                    end
                    if (cnt_n == CNT_TARGET) begin
                        state_n   = PRESSED;
                        cnt_n     = '0;
                        press_evt = 1'b1;
                    end
                end
                PRESSED: begin
                    cnt_n = (res == NONE) ? sat_inc(cnt) : '0;
                    if (cnt_n == CNT_TARGET) begin
                        state_n = RELEASED;
                        cand_n  = 4'd0;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = RELEASED;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign press_code = cand_n;
    assign key_held   = (state == PRESSED);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 active-low key matrix scanner. Drives one column low at
//                a time, samples synchronised rows at the end of each column
//                dwell, classifies each full scan, debounces it and presents
//                accepted presses on a valid/ready channel.
//  Ports       : clk     - system clock
//                rst     - asynchronous active-low reset
//                row_in  - matrix rows, active-low, asynchronous
//                col_out - one-cold column drive
//                key_if  - key output channel (master side)
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int COL_DWELL      = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_ROWS-1:0]     row_in,
    output logic [NUM_COLS-1:0]     col_out,
    keypad_scanner_if.master        key_if
);

    localparam int DW = $clog2(COL_DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL - 1);
    localparam logic [1:0]    COL_LAST   = 2'(NUM_COLS - 1);

    logic [NUM_ROWS-1:0] row_meta, row_sync;
    logic [DW-1:0]       dwell_cnt;
    logic [1:0]          col_idx;
    logic                sample, scan_end;

    logic [2:0]   low_count;
    logic         one_low, many_low;
    logic [1:0]   row_idx;

    logic [1:0]   hit_cnt, hit_tot;
    logic [3:0]   acc_code, code_tot;
    logic         acc_multi, multi_tot;
    scan_result_t result;

    logic         press_evt;
    logic [3:0]   press_code;
    logic         transfer;

    // Two-flop synchroniser; idle rows read as pulled-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign sample   = (dwell_cnt == DWELL_LAST);
    assign scan_end = sample && (col_idx == COL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
        end else begin
            dwell_cnt <= sample ? '0 : dwell_cnt + DW'(1);
            if (sample) col_idx <= col_idx + 2'd1;
        end
    end

    assign col_out = ~(4'b0001 << col_idx);

    // Classify the currently driven column.
    assign low_count = count_low_rows(row_sync);
    assign one_low   = (low_count == 3'd1);
    assign many_low  = (low_count >= 3'd2);

    always_comb begin
        row_idx = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_sync[r]) row_idx = 2'(r);
        end
    end

    // Scan totals including the column being sampled right now, so the
    // result is available in the column-3 sample cycle itself. The hit
    // count only needs to distinguish 0, 1 and "2 or more".
    assign hit_tot   = (one_low && hit_cnt != 2'd2) ? hit_cnt + 2'd1 : hit_cnt;
    assign multi_tot = acc_multi | many_low;
    assign code_tot  = one_low ? {col_idx, row_idx} : acc_code;

    always_comb begin
        if (hit_tot == 2'd0)
            result = NONE;
        else if (hit_tot == 2'd1 && !multi_tot)
            result = KEY;
        else
            result = MULTI;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt   <= 2'd0;
            acc_code  <= 4'd0;
            acc_multi <= 1'b0;
        end else if (sample) begin
            if (scan_end) begin
                hit_cnt   <= 2'd0;
                acc_code  <= 4'd0;
                acc_multi <= 1'b0;
            end else begin
                hit_cnt   <= hit_tot;
                acc_code  <= code_tot;
                acc_multi <= multi_tot;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .res_strobe (scan_end),
        .res        (result),
        .res_code   (code_tot),
        .press_evt  (press_evt),
        .press_code (press_code),
        .key_held   (key_if.key_held)
    );

    // Output holding register. A press arriving while an earlier code is
    // still unconsumed is dropped and flagged rather than overwriting it.
    assign transfer = key_if.key_valid && key_if.key_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_if.key_code  <= 4'd0;
            key_if.key_valid <= 1'b0;
            key_if.overrun   <= 1'b0;
        end else begin
            if (press_evt && (!key_if.key_valid || key_if.key_ready)) begin
                key_if.key_code  <= press_code;
                key_if.key_valid <= 1'b1;
            end else if (transfer) begin
                key_if.key_valid <= 1'b0;
            end

            if (press_evt && key_if.key_valid && !key_if.key_ready)
                key_if.overrun <= 1'b1;
            else if (transfer)
                key_if.overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner (COL_DWELL=8,
//                DEBOUNCE_SCANS=3). A key-matrix model drives row_in from a
//                set of pressed keys; a scan-level reference model predicts
//                held/valid/overrun and pushes accepted codes into a queue
//                that a handshake monitor drains.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int DWELL = 8;
    localparam int DB    = 3;
    localparam int SCAN  = 4 * DWELL;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] keys = 16'h0000;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .COL_DWELL      (DWELL),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_in  (row_in),
        .col_out (col_out),
        .key_if  (kif)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key {col,row} pulls its row low while its
    // column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4 + r] && !col_out[c]) row_in[r] = 1'b0;
    end

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    // Reference model state
    bit       m_pressed = 0;
    int       m_cnt     = 0;
    logic [3:0] m_cand  = 4'd0;
    bit       m_pend    = 0;
    bit       m_ovr     = 0;
    logic [3:0] m_code  = 4'd0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Handshake monitor
    always @(negedge clk) begin
        if (rst && kif.key_valid && kif.key_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_transfer: actual code %0h required no transfer", kif.key_code);
            end else begin
                check("transfer_code", {4'h0, kif.key_code}, {4'h0, exp_q.pop_front()});
            end
        end
    end

    // Classify a set of pressed keys as one full scan would see it.
    task automatic model_scan(input logic [15:0] k);
        int hits, n, res;
        bit multi, evt;
        logic [3:0] code;
        hits = 0; multi = 0; code = 4'd0; evt = 0;
        for (int c = 0; c < 4; c++) begin
            n = 0;
            for (int r = 0; r < 4; r++) if (k[c*4 + r]) n++;
            if (n == 1) begin
                hits++;
                for (int r = 0; r < 4; r++) if (k[c*4 + r]) code = 4'(c*4 + r);
            end else if (n >= 2) begin
                multi = 1;
            end
        end
        if (hits == 0)                res = 0;  // none
        else if (hits == 1 && !multi) res = 1;  // single key
        else                          res = 2;  // multi

        if (!m_pressed) begin
            if (res == 1) begin
                m_cnt  = (code == m_cand) ? m_cnt + 1 : 1;
                m_cand = code;
            end else begin
                m_cnt = 0;
            end
            if (m_cnt >= DB) begin
                m_pressed = 1; m_cnt = 0; evt = 1;
            end
        end else begin
            m_cnt = (res == 0) ? m_cnt + 1 : 0;
            if (m_cnt >= DB) begin
                m_pressed = 0; m_cnt = 0; m_cand = 4'd0;
            end
        end

        if (evt) begin
            if (!m_pend) begin
                m_pend = 1;
                m_code = m_cand;
                exp_q.push_back(m_cand);
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    // Run one full scan with a fixed key set and consumer readiness.
    // Must be entered in the first cycle of a scan (just after the edge).
    task automatic do_scan(input logic [15:0] k, input logic rdy);
        logic [3:0] ec;
        keys = k;
        kif.key_ready = rdy;
        if (rdy && m_pend) begin
            m_pend = 0;
            m_ovr  = 0;
        end
        for (int i = 0; i < SCAN; i++) begin
            @(negedge clk);
            ec = ~(4'b0001 << (i / DWELL));
            check("col_out", {4'h0, col_out}, {4'h0, ec});
            @(posedge clk);
        end
        #1;
        model_scan(k);
        check("key_held",  {7'h0, kif.key_held},  {7'h0, m_pressed});
        check("key_valid", {7'h0, kif.key_valid}, {7'h0, m_pend});
        check("overrun",   {7'h0, kif.overrun},   {7'h0, m_ovr});
        if (m_pend) check("key_code", {4'h0, kif.key_code}, {4'h0, m_code});
    endtask

    task automatic check_reset_values();
        check("rst_col_out",   {4'h0, col_out},       8'h0E);
        check("rst_key_code",  {4'h0, kif.key_code},  8'h00);
        check("rst_key_valid", {7'h0, kif.key_valid}, 8'h00);
        check("rst_key_held",  {7'h0, kif.key_held},  8'h00);
        check("rst_overrun",   {7'h0, kif.overrun},   8'h00);
    endtask

    task automatic model_reset();
        m_pressed = 0; m_cnt = 0; m_cand = 4'd0;
        m_pend = 0; m_ovr = 0; m_code = 4'd0;
        exp_q.delete();
    endtask

    logic [15:0] pat;
    logic        rdy;
    int          reps;

    initial begin
        kif.key_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b1;

        // Idle scans: column walk, no keys
        repeat (2) do_scan(16'h0000, 1'b1);

        // Key 0x6 (column 1, row 2), then release
        repeat (4) do_scan(16'h0040, 1'b1);
        repeat (4) do_scan(16'h0000, 1'b1);

        // Bounce: toggles every 2 scans for 8 scans, then held
        for (int i = 0; i < 8; i++) do_scan(((i / 2) % 2 == 0) ? 16'h0040 : 16'h0000, 1'b1);
        repeat (4) do_scan(16'h0040, 1'b1);
        repeat (4) do_scan(16'h0000, 1'b1);

        // Ghosting: rows 0 and 1 on column 2
        repeat (4) do_scan(16'h0300, 1'b1);
        repeat (2) do_scan(16'h0000, 1'b1);

        // Overrun: press 0x3, release, press 0x9 while unconsumed
        repeat (3) do_scan(16'h0008, 1'b0);
        repeat (3) do_scan(16'h0000, 1'b0);
        repeat (3) do_scan(16'h0200, 1'b0);
        repeat (4) do_scan(16'h0000, 1'b1);

        // Mid-press reset during the 2nd matching scan of key 0xA
        do_scan(16'h0400, 1'b1);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        repeat (4) do_scan(16'h0400, 1'b1);
        repeat (4) do_scan(16'h0000, 1'b1);

        // Randomised runs of key patterns and consumer readiness
        pat = 16'h0000;
        for (int run = 0; run < 30; run++) begin
            case ($urandom_range(0, 4))
                0: pat = 16'h0000;
                1, 2: pat = 16'h0001 << $urandom_range(0, 15);
                3: pat = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: ;  // keep previous pattern
            endcase
            rdy  = ($urandom_range(0, 3) != 0);
            reps = $urandom_range(1, 5);
            for (int j = 0; j < reps; j++) do_scan(pat, rdy);
        end

        // Drain and release
        repeat (4) do_scan(16'h0000, 1'b1);
        check("queue_empty", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4×4 active-low key matrix and returns debounced key presses as 4-bit codes. It drives one column low at a time, samples the rows, rejects bounce and multi-key ghosting, and presents each new press on a valid/ready port. It is the input-side counterpart of the multiplexed seven-segment driver: its `key_code` feeds the display's digit value.

## Interface
- `COL_DWELL`, default 1000: clock cycles each column is driven; minimum 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans needed to accept a press or a release; minimum 1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `row_in`  in  4  matrix rows, active-low, externally pulled up; asynchronous to `clk`.
- `col_out`  out  4  column drive, one-cold (exactly one bit low).
- `key_code`  out  4  accepted key, `{col_idx[1:0], row_idx[1:0]}`.
- `key_valid`  out  1  `key_code` holds an unconsumed press.
- `key_ready`  in  1  consumer accepts `key_code` when high with `key_valid`.
- `key_held`  out  1  debounced state: a key is currently down.
- `overrun`  out  1  sticky: a press was dropped because `key_valid` was still pending.

## Operation
- `row_in` passes through a 2-flop synchronizer before any use.
- Scan FSM: the column index cycles 0→1→2→3→0. `col_out = ~(4'b0001 << col_idx)`. A dwell counter runs from 0 to `COL_DWELL-1` and then wraps. `col_idx` advances on the wrap.
- Rows are sampled on dwell count `COL_DWELL-1`. This leaves settling time plus the 2-cycle synchronizer delay.
- Per-scan accumulator:
  - Zero low rows in the column: no contribution.
  - Exactly one low row: record `{col_idx,row_idx}` and increment the hit count.
  - Two or more low rows: mark the scan multi.
- Scan result at the column-3 sample:
  - NONE if the hit count is 0.
  - KEY(code) if the hit count is 1 and the scan is not multi.
  - MULTI otherwise.
- The accumulator clears for the next scan.
- Debounce FSM, states RELEASED and PRESSED, with a candidate code and a saturating match counter:
  - RELEASED: each KEY(c) scan with c equal to the candidate increments the counter. KEY(c) with a different c loads c and sets the counter to 1. NONE or MULTI clears the counter. When the counter reaches `DEBOUNCE_SCANS`: go to PRESSED, set `key_held`, and raise a press event carrying the candidate.
  - PRESSED: each NONE scan increments the release counter. Any KEY or MULTI scan clears it. When it reaches `DEBOUNCE_SCANS`: go to RELEASED, clear `key_held`, and clear the candidate. A different key pressed while in PRESSED does not produce an event until a full release.
- Output register:
  - Press event with `key_valid=0`, or with `key_valid & key_ready` in the same cycle: load `key_code` and set `key_valid`.
  - Press event with `key_valid & ~key_ready`: keep the old code and set `overrun`.
  - `key_valid & key_ready` with no event: clear `key_valid`.
  - `overrun` clears on the next completed transfer, unless a new overrun occurs in that same cycle.
- Reset may assert at any point. It immediately forces every output and state to its reset value, and scanning restarts at column 0.

## Timing
- Reset values:
  - `col_out=4'b1110`
  - `key_code=0`, `key_valid=0`, `key_held=0`, `overrun=0`
  - RELEASED state, all counters 0.
- One full scan takes `4*COL_DWELL` cycles.
- Press latency: `key_valid` and `key_held` rise 1 cycle after the column-3 sample of the `DEBOUNCE_SCANS`-th consecutive matching scan. `key_held` falls by the same rule after the release scans.
- `key_valid` stays high until it is accepted. `key_code` is stable while `key_valid=1 & key_ready=0`.
- Counter widths:
  - Dwell counter: `$clog2(COL_DWELL)`.
  - Debounce counters: `$clog2(DEBOUNCE_SCANS+1)`, saturating, never wrapping.

## Structure
- Shared package `keypad_pkg`:
  - Scan result enum: NONE, KEY, MULTI.
  - Debounce state enum: RELEASED, PRESSED.
  - Constants `NUM_COLS=4` and `NUM_ROWS=4`.
- Sub-module `keypad_debounce`: the debounce FSM. Input is the scan result plus code, with a result strobe. Outputs are the press event, code, and `key_held`. Scan FSM, synchronizer and output register stay in the top module.

## Test plan
All scenarios use `COL_DWELL=8` and `DEBOUNCE_SCANS=3` (32 cycles per scan).
- Reset release, no keys: `col_out` sequence 1110, 1101, 1011, 0111, each held 8 cycles; `key_valid` and `key_held` stay 0.
- Row 2 held low while column 1 is driven, `key_ready=1`: after 3 scans, `key_code=4'h6`, `key_valid` high for 1 cycle, `key_held=1`. After release, `key_held` falls 3 scans later.
- Bounce: the key toggles every 2 scans for 8 scans, then is held. No event until 3 consecutive matching scans, then exactly one event.
- Ghosting: rows 0 and 1 low on column 2 (MULTI) → no event, `key_held=0`.
- Overrun: `key_ready=0`; press 0x3, release, press 0x9. `key_code` stays 0x3 and `overrun=1`. Then `key_ready=1` → transfer completes and `overrun` clears.
- Mid-press reset: assert `rst` low during the 2nd matching scan. Outputs return to reset values within the reset assertion; after release, a full 3 scans are needed before the event.
